game_input_ctrl: RTL and testbench

- Parametrised input front end for the Tetris game. Replaces the raw up/left/down/right button wiring into the game controller.
- Synchronises and debounces N_BTN board buttons, and decodes PS2 make/break scancodes into the same channels.
- Merges both sources into per-channel held levels.
- Generates one-cycle move pulses with optional per-channel auto-repeat. These feed the tetris controller in place of raw levels.

---
 rtl/game_input_pkg.sv | 29 ++
 rtl/game_input_ctrl_if.sv | 20 ++
 rtl/game_input_ctrl_key_debounce.sv | 39 +++
 rtl/game_input_ctrl.sv | 127 ++++++++++++
 tb/tb_game_input_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_input_pkg.sv
// Shared constants and FSM encodings for the game input front end.
package game_input_pkg;

  localparam int CH_UP    = 0;
  localparam int CH_LEFT  = 1;
  localparam int CH_DOWN  = 2;
  localparam int CH_RIGHT = 3;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Channel 0 sits in the low byte: up=75, left=6B, down=72, right=74.
  localparam logic [31:0] KEY_CODES_DEF = {8'h74, 8'h72, 8'h6B, 8'h75};

  typedef enum logic [1:0] {
    PS2_IDLE       = 2'd0,
    PS2_IN_EXT     = 2'd1,
    PS2_IN_BRK     = 2'd2,
    PS2_IN_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_DELAY  = 2'd2,
    RPT_REPEAT = 2'd3
  } rpt_state_e;

endpackage

// File: rtl/game_input_ctrl_if.sv
// Input/command bundle between the board/PS2 side and the game controller.
interface game_input_ctrl_if #(parameter int N_BTN = 4);
  logic             enable;
  logic [N_BTN-1:0] btn_raw;
  logic             ps2_valid;
  logic [7:0]       ps2_byte;
  logic [N_BTN-1:0] key_level;
  logic [N_BTN-1:0] move_pulse;
  logic             any_held;

  modport master (
    output enable, btn_raw, ps2_valid, ps2_byte,
    input  key_level, move_pulse, any_held
  );

  modport slave (
    input  enable, btn_raw, ps2_valid, ps2_byte,
    output key_level, move_pulse, any_held
  );
endinterface

// File: rtl/game_input_ctrl_key_debounce.sv
// Two-flop synchroniser plus change-acceptance counter for one push button.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_raw,
  output logic o_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          r_sync1, r_sync2, r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;
  assign o_stable  = r_stable;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync1  <= ACTIVE_LOW;
      r_sync2  <= ACTIVE_LOW;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_pressed == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= CW'(DEBOUNCE_CYC - 1)) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/game_input_ctrl.sv
// Button/PS2 merge with per-channel move pulses and optional auto-repeat.
// PS2:    IDLE | no prefix     EXT | after E0     BRK | after F0     EXT_BRK | after E0 F0
// Repeat: IDLE | wait rise     HOLD | pulsed, no repeat   DELAY | first wait   REPEAT | periodic
module game_input_ctrl import game_input_pkg::*; #(
  parameter int                   N_BTN          = 4,
  parameter bit                   BTN_ACTIVE_LOW = 1'b1,
  parameter int                   DEBOUNCE_CYC   = 500000,
  parameter int                   REPEAT_DELAY   = 15000000,
  parameter int                   REPEAT_PERIOD  = 5000000,
  parameter logic [N_BTN-1:0]     REPEAT_EN      = 4'b1110,
  parameter logic [8*N_BTN-1:0]   KEY_CODES      = KEY_CODES_DEF
) (
  input logic               clock,
  input logic               resetn,
  game_input_ctrl_if.slave  io_bus
);
  localparam logic [1:0] S_IDLE    = PS2_IDLE;
  localparam logic [1:0] S_EXT     = PS2_IN_EXT;
  localparam logic [1:0] S_BRK     = PS2_IN_BRK;
  localparam logic [1:0] S_EXT_BRK = PS2_IN_EXT_BRK;
  localparam logic [1:0] R_IDLE    = RPT_IDLE;
  localparam logic [1:0] R_HOLD    = RPT_HOLD;
  localparam logic [1:0] R_DELAY   = RPT_DELAY;
  localparam logic [1:0] R_REPEAT  = RPT_REPEAT;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [N_BTN-1:0] w_stable, w_match, w_level, w_pulse;
  logic [N_BTN-1:0] r_ps2_held, r_level_q;
  logic [1:0]       r_ps2_st;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb (
      .clock    (clock),
      .resetn   (resetn),
      .i_raw    (io_bus.btn_raw[i]),
      .o_stable (w_stable[i])
    );
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_match[i] = (io_bus.ps2_byte == KEY_CODES[8*i +: 8]);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ps2_st   <= S_IDLE;
      r_ps2_held <= '0;
      r_level_q  <= '0;
    end else begin
      r_level_q <= w_level;
      if (io_bus.ps2_valid) begin
        case (r_ps2_st)
          S_IDLE: begin
            if (io_bus.ps2_byte == PS2_EXT)      r_ps2_st <= S_EXT;
            else if (io_bus.ps2_byte == PS2_BRK) r_ps2_st <= S_BRK;
            else                                 r_ps2_held <= r_ps2_held | w_match;
          end
          S_EXT: begin
            if (io_bus.ps2_byte == PS2_BRK) begin
              r_ps2_st <= S_EXT_BRK;
            end else begin
              r_ps2_held <= r_ps2_held | w_match;
              r_ps2_st   <= S_IDLE;
            end
          end
          default: begin
            r_ps2_held <= r_ps2_held & ~w_match;
            r_ps2_st   <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Both sources are registered, so the merged level is glitch-free without another stage.
  assign w_level = w_stable | r_ps2_held;

  for (genvar i = 0; i < N_BTN; i++) begin : g_rpt
    logic [1:0]    r_st;
    logic [RW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge clock) begin
      if (!resetn) begin
        r_st    <= R_IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!io_bus.enable || !w_level[i]) begin
          r_st  <= R_IDLE;
          r_cnt <= '0;
        end else begin
          case (r_st)
            R_IDLE: begin
              if (!r_level_q[i]) begin
                r_pulse <= 1'b1;
                r_st    <= REPEAT_EN[i] ? R_DELAY : R_HOLD;
                r_cnt   <= RW'(REPEAT_DELAY - 1);
              end
            end
            R_DELAY, R_REPEAT: begin
              if (r_cnt == '0) begin
                r_pulse <= 1'b1;
                r_st    <= R_REPEAT;
                r_cnt   <= RW'(REPEAT_PERIOD - 1);
              end else begin
                r_cnt <= r_cnt - RW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign w_pulse[i] = r_pulse;
  end

  assign io_bus.key_level  = w_level;
  assign io_bus.move_pulse = w_pulse;
  assign io_bus.any_held   = |w_level;
endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed and randomised checks of game_input_ctrl against a behavioural model.
module tb_game_input_ctrl;
  import game_input_pkg::*;

  localparam int          DEB   = 4;
  localparam int          RDLY  = 10;
  localparam int          RPER  = 3;
  localparam logic [3:0]  REN   = 4'b1110;
  localparam logic [31:0] CODES = {8'h74, 8'h72, 8'h6B, 8'h75};

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  game_input_ctrl_if #(.N_BTN(4)) bus ();

  game_input_ctrl #(
    .N_BTN(4), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .REPEAT_EN(REN), .KEY_CODES(CODES)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .io_bus (bus)
  );

  always #5 clock = ~clock;

  // Reference model: run lengths for debounce, age-since-press arithmetic for repeat.
  logic [3:0] m_s1, m_s2, m_stab, m_held, m_prev, m_pulse;
  int         m_run [4];
  int         m_age [4];
  bit         m_brk, m_ext;

  always @(posedge clock) begin
    logic [3:0] lvl_old;
    lvl_old = m_stab | m_held;
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_held = '0; m_prev = '0; m_pulse = '0;
      m_brk = 0; m_ext = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_age[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_stab[i] = ~m_stab[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
        if (!bus.enable || !lvl_old[i]) begin
          m_age[i] = 0; m_pulse[i] = 1'b0;
        end else if (m_age[i] == 0) begin
          m_pulse[i] = !m_prev[i];
          if (!m_prev[i]) m_age[i] = 1;
        end else begin
          m_age[i]++;
          m_pulse[i] = REN[i] && (m_age[i] > RDLY) && ((m_age[i] - 1 - RDLY) % RPER == 0);
        end
      end
      m_s2 = m_s1;
      m_s1 = ~bus.btn_raw;
      m_prev = lvl_old;
      if (bus.ps2_valid) begin
        if (!m_brk && bus.ps2_byte == 8'hF0) m_brk = 1;
        else if (!m_brk && !m_ext && bus.ps2_byte == 8'hE0) m_ext = 1;
        else begin
          for (int i = 0; i < 4; i++)
            if (bus.ps2_byte == CODES[8*i +: 8]) m_held[i] = !m_brk;
          m_brk = 0; m_ext = 0;
        end
      end
    end
  end

  wire [3:0] m_lvl = m_stab | m_held;
  wire [8:0] w_exp = {m_lvl, m_pulse, |m_lvl};
  wire [8:0] w_obs = {bus.key_level, bus.move_pulse, bus.any_held};

  task automatic ps2_send(input logic [7:0] b);
    bus.ps2_byte  = b;
    bus.ps2_valid = 1'b1;
    @(negedge clock);
    bus.ps2_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.btn_raw = 4'hF; bus.ps2_valid = 1'b0; bus.ps2_byte = 8'h00;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (w_obs !== 9'd0) begin errors++; $display("FAIL reset_active obs=%h exp=%h", w_obs, 9'd0); end
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== 9'd0) begin errors++; $display("FAIL reset_idle c=%0d obs=%h exp=%h", c, w_obs, 9'd0); end
    end
  endtask

  task automatic test_bounce();
    int npulse = 0, pedge = -1;
    bus.btn_raw[1] = 1'b0; repeat (3) @(negedge clock);
    bus.btn_raw[1] = 1'b1; repeat (2) @(negedge clock);
    bus.btn_raw[1] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL bounce_model e=%0d obs=%h exp=%h", e, w_obs, w_exp); end
      if (e == 5) begin
        checks++;
        if (bus.key_level[1] !== 1'b0) begin errors++; $display("FAIL bounce_level_early got=%b want=0", bus.key_level[1]); end
      end
      if (e == 6) begin
        checks++;
        if (bus.key_level[1] !== 1'b1) begin errors++; $display("FAIL bounce_level got=%b want=1", bus.key_level[1]); end
      end
      if (bus.move_pulse[1]) begin npulse++; pedge = e; end
    end
    checks++;
    if (npulse != 1 || pedge != DEB + 3) begin
      errors++; $display("FAIL bounce_pulse count=%0d edge=%0d want count=1 edge=%0d", npulse, pedge, DEB + 3);
    end
    bus.btn_raw[1] = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_repeat();
    int q[$];
    int exp_e;
    bus.btn_raw[2] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL repeat_model e=%0d obs=%h exp=%h", e, w_obs, w_exp); end
      if (bus.move_pulse[2]) q.push_back(e);
    end
    checks++;
    if (q.size() != 1 + (40 - (DEB + 3 + RDLY)) / RPER + 1) begin
      errors++; $display("FAIL repeat_count got=%0d want=9", q.size());
    end
    for (int k = 0; k < q.size() && k < 9; k++) begin
      exp_e = (k == 0) ? DEB + 3 : DEB + 3 + RDLY + (k - 1) * RPER;
      checks++;
      if (q[k] != exp_e) begin errors++; $display("FAIL repeat_edge k=%0d got=%0d want=%0d", k, q[k], exp_e); end
    end
    bus.btn_raw[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL release_model e=%0d obs=%h exp=%h", e, w_obs, w_exp); end
      if (e == 6) begin
        checks++;
        if (bus.key_level[2] !== 1'b0) begin errors++; $display("FAIL release_level got=%b want=0", bus.key_level[2]); end
      end
      if (e >= 7) begin
        checks++;
        if (bus.move_pulse[2] !== 1'b0) begin errors++; $display("FAIL release_pulse e=%0d got=1 want=0", e); end
      end
    end
  endtask

  task automatic test_no_repeat();
    int npulse = 0;
    bus.btn_raw[0] = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clock);
      if (e == 41) bus.btn_raw[0] = 1'b1;
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL norep_model e=%0d obs=%h exp=%h", e, w_obs, w_exp); end
      if (bus.move_pulse[0]) npulse++;
    end
    checks++;
    if (npulse != 1) begin errors++; $display("FAIL norep_count got=%0d want=1", npulse); end
  endtask

  task automatic test_ps2();
    ps2_send(8'hE0); @(negedge clock);
    ps2_send(8'h6B);
    checks++;
    if (bus.key_level[1] !== 1'b1 || bus.move_pulse[1] !== 1'b0) begin
      errors++; $display("FAIL ps2_make_e1 level=%b pulse=%b want level=1 pulse=0", bus.key_level[1], bus.move_pulse[1]);
    end
    @(negedge clock);
    checks++;
    if (bus.move_pulse !== 4'b0010) begin errors++; $display("FAIL ps2_make_pulse got=%b want=0010", bus.move_pulse); end
    repeat (3) @(negedge clock);
    ps2_send(8'hE0); ps2_send(8'hF0); ps2_send(8'h6B);
    @(negedge clock);
    checks++;
    if (bus.key_level[1] !== 1'b0 || bus.move_pulse !== 4'b0000) begin
      errors++; $display("FAIL ps2_break level=%b pulse=%b want level=0 pulse=0000", bus.key_level[1], bus.move_pulse);
    end
    ps2_send(8'h1C);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (bus.key_level !== 4'b0000 || bus.move_pulse !== 4'b0000) begin
        errors++; $display("FAIL ps2_unmatched level=%b pulse=%b want 0000/0000", bus.key_level, bus.move_pulse);
      end
    end
    ps2_send(8'hF0); ps2_send(8'h1C); ps2_send(8'h6B);
    @(negedge clock);
    checks++;
    if (bus.key_level[1] !== 1'b1 || bus.move_pulse !== 4'b0010) begin
      errors++; $display("FAIL ps2_brk_abort level=%b pulse=%b want level=1 pulse=0010", bus.key_level[1], bus.move_pulse);
    end
    ps2_send(8'hF0); ps2_send(8'h6B);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL ps2_model c=%0d obs=%h exp=%h", c, w_obs, w_exp); end
    end
  endtask

  task automatic test_enable_reset();
    bus.enable = 1'b0; bus.btn_raw[3] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clock);
      if (e == 20) bus.enable = 1'b1;
      checks++;
      if (bus.move_pulse !== 4'b0000) begin errors++; $display("FAIL en_off_pulse e=%0d got=%b want=0000", e, bus.move_pulse); end
    end
    checks++;
    if (bus.key_level[3] !== 1'b1) begin errors++; $display("FAIL en_off_level got=%b want=1", bus.key_level[3]); end
    for (int e = 1; e <= 10; e++) begin
      @(negedge clock);
      checks++;
      if (bus.move_pulse !== 4'b0000) begin errors++; $display("FAIL reenable_pulse e=%0d got=%b want=0000", e, bus.move_pulse); end
    end
    bus.btn_raw[3] = 1'b1;
    repeat (10) @(negedge clock);
    bus.btn_raw[3] = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL repress_model e=%0d obs=%h exp=%h", e, w_obs, w_exp); end
      if (e == DEB + 3) begin
        checks++;
        if (bus.move_pulse !== 4'b1000) begin errors++; $display("FAIL repress_pulse got=%b want=1000", bus.move_pulse); end
      end
    end
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (w_obs !== 9'd0) begin errors++; $display("FAIL mid_reset obs=%h exp=%h", w_obs, 9'd0); end
    bus.btn_raw = 4'hF;
    @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_random();
    logic [7:0] bytes [8];
    bytes = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1C, 8'hFA};
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL random_model c=%0d obs=%h exp=%h", c, w_obs, w_exp); end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
      bus.enable    = ($urandom_range(0, 19) != 0);
      bus.ps2_valid = ($urandom_range(0, 5) == 0);
      bus.ps2_byte  = bytes[$urandom_range(0, 7)];
    end
    bus.ps2_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_ps2();
    test_enable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
